// File: rtl/wb_pkg.sv
// wb_pkg: writeback mux encodings and controller state type
package wb_pkg;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] WB_RSV = 2'b11;
  typedef enum logic {IDLE, WAIT_MEM} wb_state_t;
endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: counts WAIT_MEM cycles and flags the last allowed one
module wb_timeout_cnt #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en && !o_tc) r_cnt <= r_cnt + 1'b1;
  assign o_tc = r_cnt == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/wb_ctrl_unit.sv
// wb_ctrl_unit: writeback-stage controller with a req/ack data-memory sequencer.
// Stalls while an access is outstanding and aborts it after MEM_TIMEOUT cycles.
module wb_ctrl_unit
  import wb_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid_in,
  input  logic [1:0]       wb_type_in,
  input  logic             reg_wr_in,
  input  logic             mem_wr_in,
  input  logic [4:0]       rd_in,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic [1:0]       sel_dm,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic             stall,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);
  wb_state_t        r_state, w_next;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_memop, w_load_we, w_tc, w_req, w_we, w_stall;
  logic [1:0]       w_sel;

  wb_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
    .clk  (clk),
    .rst_n(rst_n),
    .i_clr(r_state == IDLE),
    .i_en (r_state == WAIT_MEM),
    .o_tc (w_tc)
  );

  always_comb begin
    w_memop   = wb_valid_in & ((wb_type_in == WB_MEM) | mem_wr_in);
    w_load_we = (wb_type_in == WB_MEM) & ~mem_wr_in & (rd_in != 5'd0);
    w_next    = r_state;
    w_req     = 1'b0;
    w_we      = 1'b0;
    w_stall   = 1'b0;
    w_sel     = wb_type_in;
    if (r_state == IDLE) begin
      if (w_memop) begin
        w_req   = 1'b1;
        w_sel   = WB_MEM;
        w_we    = dmem_ack & w_load_we;
        w_stall = ~dmem_ack;
        w_next  = dmem_ack ? IDLE : WAIT_MEM;
      end else
        w_we = wb_valid_in & reg_wr_in & (rd_in != 5'd0) & (wb_type_in != WB_RSV);
    end else begin
      w_req   = 1'b1;
      w_sel   = WB_MEM;
      w_we    = dmem_ack & w_load_we;
      w_stall = ~dmem_ack & ~w_tc;
      w_next  = (dmem_ack | w_tc) ? IDLE : WAIT_MEM;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state        <= IDLE;
      r_mem_err      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state        <= w_next;
      r_mem_err      <= r_mem_err | ((r_state == WAIT_MEM) & w_tc & ~dmem_ack);
      r_stall_cycles <= (w_stall && !(&r_stall_cycles)) ? r_stall_cycles + 1'b1 : r_stall_cycles;
    end

  // Combinational outputs are gated so they read 0 for the whole reset window
  assign dmem_req     = rst_n & w_req;
  assign rf_we        = rst_n & w_we;
  assign stall        = rst_n & w_stall;
  assign sel_dm       = rst_n ? w_sel : 2'b00;
  assign rf_waddr     = rst_n ? rd_in : 5'd0;
  assign mem_err      = r_mem_err;
  assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_wb_ctrl_unit.sv
// tb_wb_ctrl_unit: directed vectors with hand-computed expectations for wb_ctrl_unit
module tb_wb_ctrl_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid_in, reg_wr_in, mem_wr_in, dmem_ack;
  logic [1:0]  wb_type_in;
  logic [4:0]  rd_in;
  logic        dmem_req, rf_we, stall, mem_err;
  logic [1:0]  sel_dm;
  logic [4:0]  rf_waddr;
  logic [31:0] stall_cycles;
  int n_chk = 0;
  int n_err = 0;

  wb_ctrl_unit #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid_in(wb_valid_in), .wb_type_in(wb_type_in),
    .reg_wr_in(reg_wr_in), .mem_wr_in(mem_wr_in), .rd_in(rd_in), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .sel_dm(sel_dm), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .stall(stall), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic rw, input logic mw,
                       input logic [4:0] rd, input logic ack);
    wb_valid_in = v; wb_type_in = t; reg_wr_in = rw; mem_wr_in = mw; rd_in = rd; dmem_ack = ack;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 2'b00, 1, 0, 5'd5, 0);
    #3;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_scyc", stall_cycles, 0);
    tick; tick;
    rst_n = 1'b1;
    // ALU writeback
    #1;
    chk("alu_sel", sel_dm, 2'b00);
    chk("alu_we", rf_we, 1);
    chk("alu_waddr", rf_waddr, 5'd5);
    chk("alu_stall", stall, 0);
    chk("alu_req", dmem_req, 0);
    tick;
    // Load acked on the fourth request cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b01, 1, 0, 5'd7, i == 3);
      #1;
      chk($sformatf("ld_req%0d", i), dmem_req, 1);
      chk($sformatf("ld_stall%0d", i), stall, i < 3);
      chk($sformatf("ld_we%0d", i), rf_we, i == 3);
      if (i == 3) chk("ld_sel", sel_dm, 2'b01);
      tick;
    end
    drive(0, 2'b00, 0, 0, 5'd0, 0);
    #1;
    chk("ld_scyc", stall_cycles, 3);
    chk("ld_req_off", dmem_req, 0);
    tick;
    // Load acked on the request cycle
    drive(1, 2'b01, 1, 0, 5'd9, 1);
    #1;
    chk("ld0_stall", stall, 0);
    chk("ld0_we", rf_we, 1);
    chk("ld0_sel", sel_dm, 2'b01);
    chk("ld0_req", dmem_req, 1);
    tick;
    // Load to x0, then PC+4, reserved type, stray ack, fast store
    drive(1, 2'b01, 1, 0, 5'd0, 1);
    #1;
    chk("x0_we", rf_we, 0);
    chk("x0_stall", stall, 0);
    tick;
    drive(1, 2'b10, 1, 0, 5'd1, 0);
    #1;
    chk("pc_sel", sel_dm, 2'b10);
    chk("pc_we", rf_we, 1);
    chk("pc_stall", stall, 0);
    tick;
    drive(1, 2'b11, 1, 0, 5'd2, 0);
    #1;
    chk("rsv_sel", sel_dm, 2'b11);
    chk("rsv_we", rf_we, 0);
    tick;
    drive(0, 2'b01, 0, 0, 5'd3, 1);
    #1;
    chk("ack_idle_req", dmem_req, 0);
    chk("ack_idle_we", rf_we, 0);
    chk("ack_idle_stall", stall, 0);
    tick;
    drive(1, 2'b00, 1, 1, 5'd3, 1);
    #1;
    chk("st0_we", rf_we, 0);
    chk("st0_stall", stall, 0);
    tick;
    chk("scyc_flat", stall_cycles, 3);
    // Store never acked: times out
    drive(1, 2'b00, 1, 1, 5'd3, 0);
    for (int i = 0; i < 17; i++) begin
      #1;
      chk($sformatf("to_we%0d", i), rf_we, 0);
      chk($sformatf("to_req%0d", i), dmem_req, 1);
      chk($sformatf("to_stall%0d", i), stall, i < 16);
      chk($sformatf("to_err%0d", i), mem_err, 0);
      tick;
    end
    drive(0, 2'b00, 0, 0, 5'd0, 0);
    #1;
    chk("to_err_set", mem_err, 1);
    chk("to_req_off", dmem_req, 0);
    chk("to_scyc", stall_cycles, 19);
    tick; tick;
    chk("to_err_sticky", mem_err, 1);
    // Reset in the middle of WAIT_MEM
    drive(1, 2'b01, 1, 0, 5'd4, 0);
    tick; tick;
    chk("mid_req", dmem_req, 1);
    chk("mid_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_stall", stall, 0);
    chk("arst_err", mem_err, 0);
    chk("arst_scyc", stall_cycles, 0);
    chk("arst_sel", sel_dm, 0);
    tick;
    drive(0, 2'b00, 0, 0, 5'd0, 0);
    rst_n = 1'b1;
    tick;
    chk("rel_err", mem_err, 0);
    chk("rel_scyc", stall_cycles, 0);
    chk("rel_req", dmem_req, 0);
    drive(1, 2'b01, 1, 0, 5'd6, 1);
    #1;
    chk("rel_idle_stall", stall, 0);
    chk("rel_idle_we", rf_we, 1);
    tick;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
